sprite_compositor: RTL and testbench
====================================

Name: sprite_compositor

Overview:
- Downstream of the sprite register block (staging attribute RAM, bitmap RAM, control register) and of the video timing generator.
- Shadows the staged sprite attributes into an active copy at vsync.
- Fetches one 1bpp bitmap row per scanline during horizontal blank and overlays the sprite on the background colour.
- Its 6-bit RGB output plus delayed hsync/vsync drive uo_out.

Parameters:
- SPR_ROWS, 16: sprite height in lines; bitmap rows are 8 px wide, 1 byte each.
- V_TOTAL, 525: total lines per frame; used for next-line wrap.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- pix_x  in  10  current pixel column from timing generator
- pix_y  in  10  current line from timing generator
- visible  in  1  active-video flag
- hsync_in  in  1  horizontal sync, positive polarity
- vsync_in  in  1  vertical sync, positive polarity
- bg_rgb  in  6  background colour {B,G,R}, 2 bits each
- stg_x  in  10  staged sprite X
- stg_y  in  10  staged sprite Y
- stg_color  in  6  staged sprite colour
- stg_en  in  1  staged sprite enable
- commit_req  in  1  one-cycle pulse: request staged→active copy at next vsync
- clr_hit  in  1  one-cycle pulse: clear sticky hit flag
- bmp_addr  out  4  bitmap row address (sync read, data valid the next cycle)
- bmp_data  in  8  bitmap row byte; bit 7 = leftmost pixel
- rgb_out  out  6  composited colour
- hsync_out  out  1  hsync delayed to align with rgb_out
- vsync_out  out  1  vsync delayed to align with rgb_out
- commit_done  out  1  one-cycle pulse when the active copy is updated
- hit  out  1  sticky: sprite pixel drawn over non-zero background

Behaviour:
- Clock and reset: clk; rst_n is synchronous and active-low.
- Reset values:
  - All outputs 0; active attributes 0 (sprite disabled); row_buf 0.
  - commit pending cleared; FSM in IDLE; edge-detect registers 0.
- Edge detection: registered copies of hsync_in and vsync_in; a rising edge is current 1 and previous 0.
- Commit:
  - commit_req sets the pending flag.
  - On a vsync rising edge with pending set (or commit_req high that same cycle):
    - active attributes take the stg_* values of that cycle;
    - pending clears;
    - commit_done pulses the following cycle.
  - commit_req arriving after the edge waits for the next frame.
  - Multiple requests before one edge produce a single commit.
- Line fetch FSM:
  - IDLE: on hsync rising edge go to CALC.
  - CALC: compute target line t = pix_y + 1, wrapping to 0 when pix_y = V_TOTAL-1. Compute r = t - act_y (10-bit unsigned). If act_en and r < SPR_ROWS, drive bmp_addr = r[3:0] and go to WAIT; otherwise clear row_buf and return to IDLE.
  - WAIT: one cycle for the synchronous read, then go to LOAD.
  - LOAD: row_buf <= bmp_data; return to IDLE.
  - bmp_addr holds its last value outside CALC.
  - The fetch completes within 3 cycles of the hsync edge, well before the next visible pixel.
- Pixel path:
  - Stage 1 computes dx = pix_x - act_x (10-bit unsigned); on = visible and dx < 8 and row_buf[7-dx].
  - Register the output: rgb_out <= on ? act_color : (visible ? bg_rgb : 0).
  - Latency is 1 cycle from pix_x/visible to rgb_out; hsync_out/vsync_out are delayed by 1 cycle to match.
- Wrap and clip:
  - A sprite with act_x > pix range or act_y ≥ V_TOTAL is never drawn.
  - Unsigned subtraction underflow produces large values, so the sprite clips naturally at the left and top edges.
- Hit flag:
  - Set when on and bg_rgb != 0.
  - clr_hit clears it; if set and clear occur in the same cycle, set wins.
- Reset mid-line forces IDLE and blanks output until the next hsync fetch.
- Fixed attributes: attributes used within a frame are the active copy only; stg_* changes mid-frame never tear.

Decomposition:
- Shared package:
  - RGB width constant (6);
  - sprite width constant (8);
  - FSM state enum {IDLE, CALC, WAIT, LOAD};
  - sprite attribute struct {x[9:0], y[9:0], color[5:0], en}.
- One natural sub-module, sprite_row_fetch: edge detect, FSM, bmp_addr and row_buf. The top module keeps the commit logic and the pixel mux.

Test Plan:
- Commit: stg_x=100, stg_y=50, stg_en=1, pulse commit_req mid-frame → active unchanged until the vsync rising edge; commit_done is 1 for exactly one cycle after it.
- Line fetch: bitmap row 0 = 8'hA5, sprite at (100,50). Hsync edge while pix_y=49 → bmp_addr=0 and row_buf=8'hA5 within 3 cycles. On line 50, rgb_out = act_color at pix_x = 100, 102, 105, 107 and bg_rgb at pix_x = 101, 103, 104, 106, each one cycle after pix_x.
- Clip: sprite at x=636 with row 8'hFF → only pixels 636–639 coloured; sprite at y=V_TOTAL-1 wraps so no line is drawn; line 66 (r=16) not drawn.
- Hit: bg_rgb=6'h00 under the sprite → hit stays 0. bg_rgb=6'h03 → hit=1 and stays set. Simultaneous clr_hit with a new overlap → hit remains 1.
- Reset: assert rst_n=0 during a LOAD cycle → next cycle rgb_out=0, commit_done=0, FSM IDLE, row_buf=0; no sprite drawn until a fresh commit plus vsync.

Source files
------------

// File: rtl/sprite_compositor_pkg.sv
// sprite_compositor_pkg: shared widths, fetch FSM states and sprite attribute record
package sprite_compositor_pkg;
  localparam int RGB_W = 6;
  localparam int SPR_W = 8;
  typedef enum logic [1:0] {IDLE, CALC, WAIT, LOAD} fetch_state_t;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [RGB_W-1:0] color;
    logic en;
  } spr_attr_t;
endpackage

// File: rtl/sprite_compositor_if.sv
// sprite_compositor_if: video timing, staging, bitmap RAM and output signals of the compositor
interface sprite_compositor_if;
  import sprite_compositor_pkg::*;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic visible;
  logic hsync_in;
  logic vsync_in;
  logic [RGB_W-1:0] bg_rgb;
  logic [9:0] stg_x;
  logic [9:0] stg_y;
  logic [RGB_W-1:0] stg_color;
  logic stg_en;
  logic commit_req;
  logic clr_hit;
  logic [3:0] bmp_addr;
  logic [SPR_W-1:0] bmp_data;
  logic [RGB_W-1:0] rgb_out;
  logic hsync_out;
  logic vsync_out;
  logic commit_done;
  logic hit;
  modport master (
    output pix_x, pix_y, visible, hsync_in, vsync_in, bg_rgb,
    output stg_x, stg_y, stg_color, stg_en, commit_req, clr_hit, bmp_data,
    input bmp_addr, rgb_out, hsync_out, vsync_out, commit_done, hit
  );
  modport slave (
    input pix_x, pix_y, visible, hsync_in, vsync_in, bg_rgb,
    input stg_x, stg_y, stg_color, stg_en, commit_req, clr_hit, bmp_data,
    output bmp_addr, rgb_out, hsync_out, vsync_out, commit_done, hit
  );
endinterface

// File: rtl/sprite_row_fetch.sv
// sprite_row_fetch: sync edge detect and per-line bitmap row fetch during horizontal blank
module sprite_row_fetch
  import sprite_compositor_pkg::*;
#(
  parameter int SPR_ROWS = 16,
  parameter int V_TOTAL = 525
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hsync_in,
  input  logic vsync_in,
  input  logic [9:0] pix_y,
  input  logic [9:0] act_y,
  input  logic act_en,
  input  logic [SPR_W-1:0] bmp_data,
  output logic vs_rise,
  output logic [3:0] bmp_addr,
  output logic [SPR_W-1:0] row_buf
);
  localparam logic [9:0] LAST = 10'(V_TOTAL - 1);
  fetch_state_t state, nxt;
  logic hs_q, vs_q, hs_rise, in_row;
  logic [9:0] t, r;
  assign hs_rise = hsync_in & ~hs_q;
  assign vs_rise = vsync_in & ~vs_q;
  // Fetch is for the line after the one currently in hblank.
  assign t = (pix_y == LAST) ? '0 : pix_y + 10'd1;
  assign r = t - act_y;
  assign in_row = act_en && r < 10'(SPR_ROWS);
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE: nxt = hs_rise ? CALC : IDLE;
      CALC: nxt = in_row ? WAIT : IDLE;
      WAIT: nxt = LOAD;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      bmp_addr <= '0;
      row_buf <= '0;
    end else begin
      state <= nxt;
      hs_q <= hsync_in;
      vs_q <= vsync_in;
      if (state == CALC && in_row) bmp_addr <= r[3:0];
      row_buf <= (state == LOAD) ? bmp_data : (state == CALC && !in_row) ? '0 : row_buf;
    end
  end
endmodule

// File: rtl/sprite_compositor.sv
// sprite_compositor: vsync-shadowed single sprite overlaid on the background colour
module sprite_compositor
  import sprite_compositor_pkg::*;
#(
  parameter int SPR_ROWS = 16,
  parameter int V_TOTAL = 525
) (
  input logic clk,
  input logic rst_n,
  sprite_compositor_if.slave bus
);
  spr_attr_t act;
  logic pending, vs_rise, commit, on;
  logic [9:0] dx;
  logic [SPR_W-1:0] row_buf;
  sprite_row_fetch #(.SPR_ROWS(SPR_ROWS), .V_TOTAL(V_TOTAL)) u_fetch (
    .clk(clk),
    .rst_n(rst_n),
    .hsync_in(bus.hsync_in),
    .vsync_in(bus.vsync_in),
    .pix_y(bus.pix_y),
    .act_y(act.y),
    .act_en(act.en),
    .bmp_data(bus.bmp_data),
    .vs_rise(vs_rise),
    .bmp_addr(bus.bmp_addr),
    .row_buf(row_buf)
  );
  assign commit = vs_rise & (pending | bus.commit_req);
  // Unsigned wrap makes pixels left of the sprite look far away, so clipping is free.
  assign dx = bus.pix_x - act.x;
  assign on = bus.visible && dx < 10'(SPR_W) && row_buf[3'(SPR_W - 1) - dx[2:0]];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      act <= '0;
      pending <= 1'b0;
      bus.commit_done <= 1'b0;
      bus.rgb_out <= '0;
      bus.hsync_out <= 1'b0;
      bus.vsync_out <= 1'b0;
      bus.hit <= 1'b0;
    end else begin
      if (commit) act <= '{x: bus.stg_x, y: bus.stg_y, color: bus.stg_color, en: bus.stg_en};
      pending <= commit ? 1'b0 : pending | bus.commit_req;
      bus.commit_done <= commit;
      bus.rgb_out <= on ? act.color : bus.visible ? bus.bg_rgb : '0;
      bus.hsync_out <= bus.hsync_in;
      bus.vsync_out <= bus.vsync_in;
      bus.hit <= (on && bus.bg_rgb != '0) | (bus.hit & ~bus.clr_hit);
    end
  end
endmodule

// File: tb/tb_sprite_compositor.sv
// tb_sprite_compositor: directed checks of commit, line fetch, pixel overlay, clipping, hit and reset
module tb_sprite_compositor;
  import sprite_compositor_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int errs = 0;
  logic [7:0] mem [16];
  logic [7:0] a5 = 8'hA5;
  sprite_compositor_if bus ();
  sprite_compositor #(.SPR_ROWS(16), .V_TOTAL(525)) u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) bus.bmp_data <= mem[bus.bmp_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fetch(input logic [9:0] y);
    bus.pix_y = y;
    bus.hsync_in = 1'b1;
    tick();
    bus.hsync_in = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic commit_frame(input logic [9:0] x, input logic [9:0] y);
    bus.stg_x = x;
    bus.stg_y = y;
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    bus.vsync_in = 1'b1;
    tick();
    bus.vsync_in = 1'b0;
    tick();
  endtask

  task automatic pix(input logic [9:0] x, input logic vis, input logic [5:0] exp, input string tag);
    bus.pix_x = x;
    bus.visible = vis;
    tick();
    chk(tag, 16'(bus.rgb_out), 16'(exp));
  endtask

  initial begin
    mem[0] = a5;
    for (int i = 1; i < 16; i++) mem[i] = 8'hFF;
    rst_n = 1'b0;
    bus.pix_x = '0; bus.pix_y = '0; bus.visible = 1'b0;
    bus.hsync_in = 1'b0; bus.vsync_in = 1'b0; bus.bg_rgb = '0;
    bus.stg_x = '0; bus.stg_y = '0; bus.stg_color = '0; bus.stg_en = 1'b0;
    bus.commit_req = 1'b0; bus.clr_hit = 1'b0;
    tick();
    tick();
    chk("rst_rgb", 16'(bus.rgb_out), 16'h0);
    chk("rst_hit", 16'(bus.hit), 16'h0);
    chk("rst_done", 16'(bus.commit_done), 16'h0);
    chk("rst_hs", 16'(bus.hsync_out), 16'h0);
    chk("rst_state", 16'(u_dut.u_fetch.state), 16'(IDLE));
    chk("rst_rowbuf", 16'(u_dut.u_fetch.row_buf), 16'h0);
    rst_n = 1'b1;
    // staged mid-frame, commit only at the vsync edge
    bus.stg_x = 10'd100; bus.stg_y = 10'd50; bus.stg_color = 6'h30; bus.stg_en = 1'b1;
    bus.commit_req = 1'b1;
    tick();
    bus.commit_req = 1'b0;
    tick();
    chk("pre_done", 16'(bus.commit_done), 16'h0);
    chk("pre_actx", 16'(u_dut.act.x), 16'h0);
    bus.vsync_in = 1'b1;
    tick();
    chk("vs_done", 16'(bus.commit_done), 16'h1);
    chk("vs_actx", 16'(u_dut.act.x), 16'd100);
    chk("vs_out", 16'(bus.vsync_out), 16'h1);
    tick();
    chk("vs_done_once", 16'(bus.commit_done), 16'h0);
    bus.vsync_in = 1'b0;
    tick();
    // two requests before one edge give a single commit
    bus.commit_req = 1'b1;
    tick();
    tick();
    bus.commit_req = 1'b0;
    tick();
    chk("dbl_pre", 16'(bus.commit_done), 16'h0);
    bus.vsync_in = 1'b1;
    tick();
    chk("dbl_done", 16'(bus.commit_done), 16'h1);
    tick();
    chk("dbl_once", 16'(bus.commit_done), 16'h0);
    bus.vsync_in = 1'b0;
    tick();
    // line fetch for line 50
    bus.pix_y = 10'd49;
    bus.hsync_in = 1'b1;
    tick();
    chk("hs_out", 16'(bus.hsync_out), 16'h1);
    bus.hsync_in = 1'b0;
    tick();
    chk("f_wait", 16'(u_dut.u_fetch.state), 16'(WAIT));
    chk("f_addr", 16'(bus.bmp_addr), 16'h0);
    tick();
    tick();
    chk("f_row", 16'(u_dut.u_fetch.row_buf), 16'hA5);
    chk("f_idle", 16'(u_dut.u_fetch.state), 16'(IDLE));
    bus.pix_y = 10'd50;
    pix(10'd99, 1'b1, 6'h00, "px99");
    pix(10'd100, 1'b1, 6'h30, "px100");
    pix(10'd101, 1'b1, 6'h00, "px101");
    pix(10'd102, 1'b1, 6'h30, "px102");
    pix(10'd103, 1'b1, 6'h00, "px103");
    pix(10'd104, 1'b1, 6'h00, "px104");
    pix(10'd105, 1'b1, 6'h30, "px105");
    pix(10'd106, 1'b1, 6'h00, "px106");
    pix(10'd107, 1'b1, 6'h30, "px107");
    pix(10'd108, 1'b1, 6'h00, "px108");
    chk("hit_zero_bg", 16'(bus.hit), 16'h0);
    bus.bg_rgb = 6'h03;
    pix(10'd101, 1'b1, 6'h03, "bg101");
    chk("hit_off", 16'(bus.hit), 16'h0);
    pix(10'd100, 1'b1, 6'h30, "hit100");
    chk("hit_set", 16'(bus.hit), 16'h1);
    pix(10'd101, 1'b1, 6'h03, "hit101");
    chk("hit_sticky", 16'(bus.hit), 16'h1);
    bus.clr_hit = 1'b1;
    pix(10'd102, 1'b1, 6'h30, "clr102");
    chk("hit_set_wins", 16'(bus.hit), 16'h1);
    pix(10'd103, 1'b1, 6'h03, "clr103");
    chk("hit_cleared", 16'(bus.hit), 16'h0);
    bus.clr_hit = 1'b0;
    pix(10'd100, 1'b0, 6'h00, "blank100");
    // last sprite row, then first line past it
    fetch(10'd64);
    chk("r15_addr", 16'(bus.bmp_addr), 16'd15);
    chk("r15_row", 16'(u_dut.u_fetch.row_buf), 16'hFF);
    fetch(10'd65);
    chk("r16_row", 16'(u_dut.u_fetch.row_buf), 16'h0);
    pix(10'd100, 1'b1, 6'h03, "r16_px");
    // right-edge clip
    bus.bg_rgb = 6'h01;
    commit_frame(10'd636, 10'd10);
    fetch(10'd10);
    chk("cx_row", 16'(u_dut.u_fetch.row_buf), 16'hFF);
    pix(10'd634, 1'b1, 6'h01, "cx634");
    pix(10'd635, 1'b1, 6'h01, "cx635");
    pix(10'd636, 1'b1, 6'h30, "cx636");
    pix(10'd637, 1'b1, 6'h30, "cx637");
    pix(10'd638, 1'b1, 6'h30, "cx638");
    pix(10'd639, 1'b1, 6'h30, "cx639");
    pix(10'd0, 1'b1, 6'h01, "cx0");
    pix(10'd3, 1'b1, 6'h01, "cx3");
    // sprite on the last frame line only reaches invisible line 524
    commit_frame(10'd100, 10'd524);
    fetch(10'd523);
    chk("wy_row523", 16'(u_dut.u_fetch.row_buf), 16'hA5);
    pix(10'd100, 1'b0, 6'h00, "wy_blank");
    fetch(10'd524);
    chk("wy_row0", 16'(u_dut.u_fetch.row_buf), 16'h0);
    pix(10'd100, 1'b1, 6'h01, "wy_px");
    // reset while loading a row
    commit_frame(10'd100, 10'd50);
    bus.pix_y = 10'd49;
    bus.hsync_in = 1'b1;
    tick();
    bus.hsync_in = 1'b0;
    tick();
    tick();
    chk("rl_load", 16'(u_dut.u_fetch.state), 16'(LOAD));
    bus.visible = 1'b1;
    bus.pix_x = 10'd100;
    rst_n = 1'b0;
    tick();
    chk("rl_rgb", 16'(bus.rgb_out), 16'h0);
    chk("rl_done", 16'(bus.commit_done), 16'h0);
    chk("rl_state", 16'(u_dut.u_fetch.state), 16'(IDLE));
    chk("rl_row", 16'(u_dut.u_fetch.row_buf), 16'h0);
    rst_n = 1'b1;
    bus.bg_rgb = 6'h02;
    bus.vsync_in = 1'b1;
    tick();
    chk("rl_nocommit", 16'(bus.commit_done), 16'h0);
    bus.vsync_in = 1'b0;
    tick();
    fetch(10'd49);
    chk("rl_row_off", 16'(u_dut.u_fetch.row_buf), 16'h0);
    pix(10'd100, 1'b1, 6'h02, "rl_px");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
